// File: rtl/id_stage_pipe.sv
// RV32I instruction-decode stage. The decode is captured into a main output register.
// A one-entry skid register lets in_ready be a registered signal and never drop an instruction.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [XLEN-1:0]     out_imm,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [2:0]          out_fmt,
  output logic                out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [XLEN-1:0]     imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [2:0]          fmt;
    logic                illegal;
  } dec_t;

  dec_t               dec;
  dec_t               main_q;
  dec_t               main_d;
  dec_t               skid_q;
  dec_t               skid_d;
  logic               main_valid_q;
  logic               main_valid_d;
  logic               skid_valid_q;
  logic               skid_valid_d;
  logic               in_ready_q;
  logic               accept;
  logic signed [31:0] imm32;

  // The immediate is built as a 32-bit signed value and then widened by a signed cast.
  // The widening copies instr[31] into bits XLEN-1:32 when XLEN=64.
  always_comb begin
    imm32       = '0;
    dec         = '0;
    dec.pc      = in_pc;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.opcode  = in_instr[6:0];
    dec.funct3  = in_instr[14:12];
    dec.funct7  = in_instr[31:25];
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b1;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      7'b0110011: dec.fmt = FMT_R;
      default:    dec.fmt = FMT_ILL;
    endcase
    dec.illegal = (dec.fmt == FMT_ILL);
    dec.imm     = XLEN'(imm32);
  end

  assign accept = in_valid & in_ready_q;

  // The skid register is only loaded while in_ready is high, and in_ready is !skid_valid.
  // So an accept and a pending skid entry never compete for the main register.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_opcode  = main_q.opcode;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule
